// File: rtl/axis_video_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module   : axis_video_frame_checker
//  Purpose  : AXI4-Stream video sink / monitor. Checks SOF/EOL framing
//             against a programmed resolution, counts frames, accumulates a
//             per-frame pixel checksum, applies controllable backpressure
//             and keeps sticky framing-error flags.
//  Revision : 1.0  initial release
// ============================================================================
module axis_video_frame_checker #(
   parameter int C_WIDTH     = 24,
   parameter int TUSER_WIDTH = 1,
   parameter int HRES_WIDTH  = 12,
   parameter int VRES_WIDTH  = 12
) (
   input  logic                   i_axis_clk,
   input  logic                   i_axis_reset,
   input  logic                   i_tvalid,
   output logic                   o_tready,
   input  logic [C_WIDTH-1:0]     i_tdata,
   input  logic [TUSER_WIDTH-1:0] i_tuser,
   input  logic                   i_tlast,
   input  logic [HRES_WIDTH-1:0]  i_hres,
   input  logic [VRES_WIDTH-1:0]  i_vres,
   input  logic                   i_sink_ready,
   input  logic                   i_clear,
   output logic                   o_frame_done,
   output logic [15:0]            o_frame_count,
   output logic [31:0]            o_checksum,
   output logic [15:0]            o_drop_count,
   output logic                   o_err_sof_missing,
   output logic                   o_err_sof_early,
   output logic                   o_err_eol_early,
   output logic                   o_err_eol_late,
   output logic                   o_error
);

   localparam logic [HRES_WIDTH-1:0] H_ONE = {{(HRES_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [VRES_WIDTH-1:0] V_ONE = {{(VRES_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   state_t                  state;
   logic [HRES_WIDTH-1:0]   hres_q;
   logic [VRES_WIDTH-1:0]   vres_q;
   logic [HRES_WIDTH-1:0]   x;
   logic [VRES_WIDTH-1:0]   y;
   logic [31:0]             acc_sum;

   // Beat-level view: which position/resolution/sum this beat is judged with
   logic                    accept;
   logic                    sof;
   logic                    tracked;
   logic [HRES_WIDTH-1:0]   cur_hres;
   logic [VRES_WIDTH-1:0]   cur_vres;
   logic [HRES_WIDTH-1:0]   cur_x;
   logic [VRES_WIDTH-1:0]   cur_y;
   logic [31:0]             cur_sum;
   logic [31:0]             data_ext;
   logic                    x_last;
   logic                    y_last;
   logic                    eol_early;
   logic                    eol_late;
   logic                    line_end;

   // Ready is held low during reset so nothing is consumed while flushing
   assign o_tready = i_sink_ready & ~i_axis_reset;
   assign accept   = i_tvalid & o_tready;
   assign sof      = i_tuser[0];
   // A SOF beat is always tracked; non-SOF beats only while inside a frame
   assign tracked  = accept & (sof | (state == ACTIVE));
   assign data_ext = 32'(i_tdata);
   assign o_error  = o_err_sof_missing | o_err_sof_early | o_err_eol_early | o_err_eol_late;

   // A SOF beat restarts position and sum, and uses the freshly sampled resolution
   always_comb begin
      cur_hres = hres_q;
      cur_vres = vres_q;
      cur_x    = x;
      cur_y    = y;
      cur_sum  = acc_sum + data_ext;
      if (sof) begin
         cur_hres = i_hres;
         cur_vres = i_vres;
         cur_x    = '0;
         cur_y    = '0;
         cur_sum  = data_ext;
      end
      x_last    = (cur_x == (cur_hres - H_ONE));
      y_last    = (cur_y == (cur_vres - V_ONE));
      eol_early = i_tlast & ~x_last;
      eol_late  = ~i_tlast & x_last;
      line_end  = i_tlast | x_last;
   end

   // Frame tracking FSM, counters, checksum and sticky flags
   always_ff @(posedge i_axis_clk) begin
      if (i_axis_reset) begin
         state             <= WAIT_SOF;
         hres_q            <= '0;
         vres_q            <= '0;
         x                 <= '0;
         y                 <= '0;
         acc_sum           <= '0;
         o_frame_done      <= 1'b0;
         o_frame_count     <= '0;
         o_checksum        <= '0;
         o_drop_count      <= '0;
         o_err_sof_missing <= 1'b0;
         o_err_sof_early   <= 1'b0;
         o_err_eol_early   <= 1'b0;
         o_err_eol_late    <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;

         // Clear first so that a flag being set in the same cycle wins
         if (i_clear) begin
            o_err_sof_missing <= 1'b0;
            o_err_sof_early   <= 1'b0;
            o_err_eol_early   <= 1'b0;
            o_err_eol_late    <= 1'b0;
            o_drop_count      <= '0;
         end

         // Beat discarded while hunting for start of frame
         if (accept && !tracked) begin
            o_err_sof_missing <= 1'b1;
            if (i_clear)
               o_drop_count <= 16'd1;
            else if (o_drop_count != 16'hFFFF)
               o_drop_count <= o_drop_count + 16'd1;
         end

         if (tracked) begin
            if (sof) begin
               hres_q <= i_hres;
               vres_q <= i_vres;
               if (state == ACTIVE)
                  o_err_sof_early <= 1'b1;
            end
            if (eol_early)
               o_err_eol_early <= 1'b1;
            if (eol_late)
               o_err_eol_late <= 1'b1;

            if (line_end) begin
               x <= '0;
               if (y_last) begin
                  y             <= '0;
                  acc_sum       <= '0;
                  o_checksum    <= cur_sum;
                  o_frame_count <= o_frame_count + 16'd1;
                  o_frame_done  <= 1'b1;
                  state         <= WAIT_SOF;
               end else begin
                  y       <= cur_y + V_ONE;
                  acc_sum <= cur_sum;
                  state   <= ACTIVE;
               end
            end else begin
               x       <= cur_x + H_ONE;
               y       <= cur_y;
               acc_sum <= cur_sum;
               state   <= ACTIVE;
            end
         end
      end
   end

endmodule
`default_nettype wire
